// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional
// 2-entry skid buffer, flush (bubble insert) and a saturating stall counter.
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FIELDS = 5,
  parameter int CTRL_WIDTH = 6,
  parameter int SKID_EN    = 1
) (
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic [15:0]                      stall_cycles
);
  localparam int PW = NUM_FIELDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_out_valid;
  logic            r_in_ready;
  logic [PW-1:0]   r_main_data;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [PW-1:0]   r_skid_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;
  logic [15:0]     r_stall;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  // Without the skid entry, ready must look through to the downstream ready.
  assign w_in_ready = (SKID_EN != 0) ? r_in_ready : (!r_out_valid || out_ready);
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_main_data;
  assign out_ctrl     = r_main_ctrl;
  assign stall_cycles = r_stall;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_next_state   = ST_FULL;
          w_load_main_in = 1'b1;
        end else begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_next_state   = ST_FULL;
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          // Only reachable with the skid entry: in_ready stays high while stalled.
          if (SKID_EN != 0) begin
            w_next_state = ST_SKID;
            w_load_skid  = 1'b1;
          end else begin
            w_next_state = ST_FULL;
          end
        end else if (w_out_fire) begin
          w_next_state = ST_EMPTY;
        end else begin
          w_next_state = ST_FULL;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_next_state     = ST_FULL;
          w_load_main_skid = 1'b1;
        end else begin
          w_next_state = ST_SKID;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_stall     <= 16'd0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
      if (flush) begin
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end else begin
        r_state     <= w_next_state;
        r_out_valid <= (w_next_state != ST_EMPTY);
        r_in_ready  <= (w_next_state != ST_SKID);
        if (w_load_main_in) begin
          r_main_data <= in_data;
          r_main_ctrl <= in_ctrl;
        end else if (w_load_main_skid) begin
          r_main_data <= r_skid_data;
          r_main_ctrl <= r_skid_ctrl;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end
        if (w_load_skid) begin
          r_skid_data <= in_data;
          r_skid_ctrl <= in_ctrl;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid build and a no-skid build share stimulus and
// are checked every cycle against a queue model, plus directed literal checks.
module tb_pipe_stage_skid;
  localparam int DW = 160;

  logic clock = 1'b0;
  logic clear, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [5:0] in_ctrl;

  logic s_in_ready, s_out_valid, n_in_ready, n_out_valid;
  logic [DW-1:0] s_out_data, n_out_data;
  logic [5:0] s_out_ctrl, n_out_ctrl;
  logic [15:0] s_stall, n_stall;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  localparam logic [DW-1:0] DA = {5{32'h11111111}};
  localparam logic [DW-1:0] DB = {5{32'h22222222}};
  localparam logic [DW-1:0] DC = {5{32'h33333333}};
  localparam logic [DW-1:0] DD = {5{32'h44444444}};

  always #5 clock = ~clock;

  pipe_stage_skid #(.SKID_EN(1)) dut (
    .clock(clock), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .stall_cycles(s_stall)
  );

  pipe_stage_skid #(.SKID_EN(0)) dut0 (
    .clock(clock), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .stall_cycles(n_stall)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: each build is a FIFO of capacity 2 (skid) or 1 (no skid).
  typedef struct packed { logic [DW-1:0] d; logic [5:0] c; } ent_t;
  ent_t        mq [2][2];
  int          mcnt [2];
  ent_t        mlast [2];
  logic [15:0] mstall [2];
  logic        mrdy0 = 1'b1;
  logic        m_rdy, m_inf, m_outf;
  ent_t        m_head;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mlast[k] = '0; mstall[k] = 16'd0;
    end
    forever begin
      @(posedge clock);
      for (int k = 0; k < 2; k++) begin
        m_rdy = (k == 0) ? mrdy0 : ((mcnt[1] == 0) || out_ready);
        if (clear) begin
          mcnt[k] = 0; mlast[k] = '0; mstall[k] = 16'd0;
        end else begin
          if (mcnt[k] > 0 && !out_ready && mstall[k] != 16'hFFFF) mstall[k] = mstall[k] + 16'd1;
          if (flush) begin
            mcnt[k] = 0; mlast[k] = '0;
          end else begin
            m_inf  = in_valid && m_rdy;
            m_outf = (mcnt[k] > 0) && out_ready;
            if (m_outf) begin
              mlast[k] = mq[k][0]; mq[k][0] = mq[k][1]; mcnt[k] = mcnt[k] - 1;
            end
            if (m_inf) begin
              mq[k][mcnt[k]] = {in_data, in_ctrl}; mcnt[k] = mcnt[k] + 1;
            end
          end
        end
        if (k == 0) mrdy0 = (mcnt[0] < 2);
      end
      @(negedge clock);
      if (started) begin
        m_head = (mcnt[0] > 0) ? mq[0][0] : mlast[0];
        chk("skid.out_valid", DW'(s_out_valid), DW'(mcnt[0] > 0));
        chk("skid.out_data", s_out_data, m_head.d);
        chk("skid.out_ctrl", DW'(s_out_ctrl), DW'(m_head.c));
        chk("skid.in_ready", DW'(s_in_ready), DW'(mrdy0));
        chk("skid.stall", DW'(s_stall), DW'(mstall[0]));
        m_head = (mcnt[1] > 0) ? mq[1][0] : mlast[1];
        chk("noskid.out_valid", DW'(n_out_valid), DW'(mcnt[1] > 0));
        chk("noskid.out_data", n_out_data, m_head.d);
        chk("noskid.out_ctrl", DW'(n_out_ctrl), DW'(m_head.c));
        chk("noskid.in_ready", DW'(n_in_ready), DW'((mcnt[1] == 0) || out_ready));
        chk("noskid.stall", DW'(n_stall), DW'(mstall[1]));
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [5:0] c,
                       input logic r, input logic f, input logic cl);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f; clear = cl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(1'b1, DC, 6'h0C, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    drive(1'b0, '0, 6'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("rst.out_valid", DW'(s_out_valid), DW'(1'b0));
    chk("rst.out_data", s_out_data, '0);
    chk("rst.out_ctrl", DW'(s_out_ctrl), DW'(6'h00));
    chk("rst.stall", DW'(s_stall), DW'(16'd0));
    chk("rst.in_ready", DW'(s_in_ready), DW'(1'b1));
    chk("rst.n_in_ready", DW'(n_in_ready), DW'(1'b1));
    started = 1'b1;

    // Streaming A then B with downstream always ready.
    tick(); drive(1'b1, DA, 6'h05, 1'b1, 1'b0, 1'b0);
    tick(); drive(1'b1, DB, 6'h0A, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("stream.A_data", s_out_data, DA);
    chk("stream.A_ctrl", DW'(s_out_ctrl), DW'(6'h05));
    chk("stream.A_ready", DW'(s_in_ready), DW'(1'b1));
    tick(); drive(1'b0, '0, 6'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("stream.B_data", s_out_data, DB);
    chk("stream.B_ctrl", DW'(s_out_ctrl), DW'(6'h0A));
    tick();
    @(negedge clock);
    chk("stream.drained", DW'(s_out_valid), DW'(1'b0));
    chk("stream.held", s_out_data, DB);

    // Skid fill with downstream stalled, then release.
    drive(1'b1, DA, 6'h05, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, DB, 6'h0A, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b0, '0, 6'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("skid.full_ready", DW'(s_in_ready), DW'(1'b0));
    chk("skid.full_data", s_out_data, DA);
    chk("skid.stall1", DW'(s_stall), DW'(16'd1));
    tick();
    @(negedge clock);
    chk("skid.stall2", DW'(s_stall), DW'(16'd2));
    tick(); drive(1'b0, '0, 6'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("skid.stall3", DW'(s_stall), DW'(16'd3));
    tick();
    @(negedge clock);
    chk("skid.B_after_A", s_out_data, DB);
    chk("skid.ready_after_A", DW'(s_in_ready), DW'(1'b1));
    tick();
    @(negedge clock);
    chk("skid.drained", DW'(s_out_valid), DW'(1'b0));

    // Flush while in SKID, with C offered on the same cycle.
    drive(1'b1, DA, 6'h05, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, DB, 6'h0A, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, DC, 6'h0C, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    chk("flush.pre_ready", DW'(s_in_ready), DW'(1'b0));
    tick(); drive(1'b0, '0, 6'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("flush.out_valid", DW'(s_out_valid), DW'(1'b0));
    chk("flush.out_data", s_out_data, '0);
    chk("flush.out_ctrl", DW'(s_out_ctrl), DW'(6'h00));
    chk("flush.in_ready", DW'(s_in_ready), DW'(1'b1));
    chk("flush.stall", DW'(s_stall), DW'(16'd4));
    repeat (2) tick();
    @(negedge clock);
    chk("flush.no_C", DW'(s_out_valid), DW'(1'b0));

    // No-skid build: combinational ready follows out_ready within the cycle.
    drive(1'b1, DA, 6'h05, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clock);
    chk("noskid.stalled_ready", DW'(n_in_ready), DW'(1'b0));
    #1; drive(1'b1, DD, 6'h0D, 1'b1, 1'b0, 1'b0); #1;
    chk("noskid.release_ready", DW'(n_in_ready), DW'(1'b1));
    tick(); drive(1'b0, '0, 6'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("noskid.D_data", n_out_data, DD);
    chk("noskid.D_ctrl", DW'(n_out_ctrl), DW'(6'h0D));
    chk("skid.D_data", s_out_data, DD);

    // Saturation of the stall counter.
    repeat (70000) tick();
    @(negedge clock);
    chk("sat.skid", DW'(s_stall), DW'(16'hFFFF));
    chk("sat.noskid", DW'(n_stall), DW'(16'hFFFF));
    repeat (3) tick();
    @(negedge clock);
    chk("sat.nowrap", DW'(s_stall), DW'(16'hFFFF));

    // Clear mid-operation also zeroes the counter.
    tick(); drive(1'b0, '0, 6'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b0, '0, 6'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("clr.stall", DW'(s_stall), DW'(16'd0));
    chk("clr.out_valid", DW'(s_out_valid), DW'(1'b0));
    chk("clr.in_ready", DW'(s_in_ready), DW'(1'b1));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
